sregister_decoder: RTL and testbench
====================================

Name: sregister_decoder

Overview:
Special-register write-select decoder in the processor datapath. It converts a 4-bit special-register index into a one-hot write-control vector, one bit per special register (8 registers). The output is registered so that the write strobes are glitch-free and aligned with the register-file write edge. Indices outside the implemented range produce no write strobe and raise an invalid flag.

Parameters:
- NUM_SREG, 8, number of special registers; width of the one-hot output.
- SEL_W, 4, width of the select index; must satisfy 2**SEL_W >= NUM_SREG.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  input  1  write request; when low, no strobe is generated.
- sel  input  SEL_W (4)  special-register index, 0..15.
- sreg_wr_ctrl_signals  output  NUM_SREG (8)  registered one-hot write strobes; bit i selects special register i.
- sel_invalid  output  1  registered flag: the last sampled request had sel >= NUM_SREG.

Behaviour:
- One clock, one synchronous active-low reset. No asynchronous paths.
- Reset: if rst_n = 0 at a rising edge, sreg_wr_ctrl_signals <= 8'h00 and sel_invalid <= 0. Reset has priority over all other inputs.
- Normal operation: at each rising edge with rst_n = 1:
  - If wr_en = 1 and sel < NUM_SREG: sreg_wr_ctrl_signals <= (1 << sel) and sel_invalid <= 0.
  - If wr_en = 1 and sel >= NUM_SREG (8..15): sreg_wr_ctrl_signals <= 8'h00 and sel_invalid <= 1.
  - If wr_en = 0: sreg_wr_ctrl_signals <= 8'h00 and sel_invalid <= 0, regardless of sel.
- Latency: exactly 1 cycle from sampled sel/wr_en to the output. The outputs hold for one cycle per request; there is no handshake and no backpressure.
- Invariant: at most one bit of sreg_wr_ctrl_signals is set, $onehot0 at all times.
- sel_invalid = 1 implies sreg_wr_ctrl_signals = 0.
- Consecutive requests to different indices switch the strobe cleanly, with no overlap or gap cycle.
- Reset mid-operation clears the outputs at the next edge. The first request after reset deassertion appears one cycle later.
- X/Z on sel while wr_en = 0 must not propagate to the outputs.
- Width rule: the index comparison is done on the full SEL_W bits. Upper bits must not be truncated (sel = 9 must not alias to register 1).

Decomposition:
- Shared package sreg_pkg:
  - localparams NUM_SREG = 8 and SEL_W = 4.
  - typedef sreg_sel_t = logic [SEL_W-1:0].
  - typedef sreg_onehot_t = logic [NUM_SREG-1:0].
- Sub-module sreg_onehot_dec: purely combinational. It takes sel and returns the one-hot vector plus the out-of-range flag. The top level adds wr_en gating and the output register stage.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with wr_en = 1, sel = 3 -> outputs 8'h00, sel_invalid = 0. Release reset -> next edge gives 8'h08.
- Full sweep: wr_en = 1, sel = 0..7 on consecutive cycles -> outputs 8'h01, 02, 04, 08, 10, 20, 40, 80, each one cycle after its sel. Check $onehot every cycle.
- Out of range: sel = 8 -> 8'h00, sel_invalid = 1. sel = 9 -> 8'h00, sel_invalid = 1 (no alias to 8'h02). sel = 15 -> 8'h00, sel_invalid = 1.
- Mixed sequence: sel = 2, 7, 1, 8, 3, 4, 6, 5, 0, 9 -> 04, 80, 02, 00 (invalid), 08, 10, 40, 20, 01, 00 (invalid).
- Gating: wr_en = 0 with sel = 5 -> 8'h00, sel_invalid = 0. Toggle wr_en to 1 -> 8'h20 on the next edge.
- Reset mid-stream: strobe 8'h40 active, assert rst_n = 0 for one edge -> 8'h00 at that edge even with wr_en = 1.

Source files
------------

// File: rtl/sregister_decoder_pkg.sv
// Shared types and sizing for the special-register write-select decoder.
package sreg_pkg;

  localparam int unsigned NUM_SREG = 8;
  localparam int unsigned SEL_W    = 4;

  typedef logic [SEL_W-1:0]    sreg_sel_t;
  typedef logic [NUM_SREG-1:0] sreg_onehot_t;

endpackage : sreg_pkg

// File: rtl/sregister_decoder_if.sv
// Request/strobe bundle between the datapath control and the special-register decoder.
interface sregister_decoder_if;
  import sreg_pkg::*;

  logic         wr_en;
  sreg_sel_t    sel;
  sreg_onehot_t sreg_wr_ctrl_signals;
  logic         sel_invalid;

  // Requester side: drives the index and write request, observes strobes.
  modport master (
    output wr_en,
    output sel,
    input  sreg_wr_ctrl_signals,
    input  sel_invalid
  );

  // Decoder side: consumes the request, produces registered strobes.
  modport slave (
    input  wr_en,
    input  sel,
    output sreg_wr_ctrl_signals,
    output sel_invalid
  );

endinterface : sregister_decoder_if

// File: rtl/sregister_decoder_onehot_dec.sv
// Combinational index-to-one-hot decoder with out-of-range detection.
module sreg_onehot_dec
  import sreg_pkg::*;
(
  input  sreg_sel_t    sel_i,
  output sreg_onehot_t onehot_o,
  output logic         invalid_o
);

  // Compare against the full index width so out-of-range values never alias
  // onto a low register number.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_SREG; i++) begin
      onehot_o[i] = (sel_i == sreg_sel_t'(i));
    end
    invalid_o = (sel_i >= sreg_sel_t'(NUM_SREG));
  end

endmodule : sreg_onehot_dec

// File: rtl/sregister_decoder.sv
// Registered special-register write-strobe generator: one-hot decode, wr_en gating,
// single output register stage with synchronous active-low reset.
module sregister_decoder
  import sreg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  sregister_decoder_if.slave  bus
);

  sreg_onehot_t dec_onehot;
  logic         dec_invalid;

  sreg_onehot_t strobe_d, strobe_q;
  logic         invalid_d, invalid_q;

  sreg_onehot_dec u_dec (
    .sel_i     (bus.sel),
    .onehot_o  (dec_onehot),
    .invalid_o (dec_invalid)
  );

  // Gate by wr_en; the idle branch uses constants so an unknown sel cannot leak through.
  always_comb begin
    strobe_d  = '0;
    invalid_d = 1'b0;
    if (bus.wr_en == 1'b1) begin
      strobe_d  = dec_onehot;
      invalid_d = dec_invalid;
    end
  end

  // Output register; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      strobe_q  <= strobe_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.sreg_wr_ctrl_signals = strobe_q;
  assign bus.sel_invalid          = invalid_q;

endmodule : sregister_decoder

// File: tb/tb_sregister_decoder.sv
// Directed bench for sregister_decoder with hand-computed expected strobes.
module tb_sregister_decoder;
  import sreg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  sregister_decoder_if bus ();

  sregister_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_vec, input logic exp_inv);
    n_cmp++;
    assert (bus.sreg_wr_ctrl_signals === exp_vec) else begin
      n_err++;
      $error("FAIL %s strobe: got %h want %h", tag, bus.sreg_wr_ctrl_signals, exp_vec);
    end
    n_cmp++;
    assert (bus.sel_invalid === exp_inv) else begin
      n_err++;
      $error("FAIL %s invalid: got %b want %b", tag, bus.sel_invalid, exp_inv);
    end
    n_cmp++;
    assert ($onehot0(bus.sreg_wr_ctrl_signals)) else begin
      n_err++;
      $error("FAIL %s onehot0: got %h want at most one bit", tag, bus.sreg_wr_ctrl_signals);
    end
  endtask

  logic [3:0] mix_sel [10];
  logic [7:0] mix_vec [10];
  logic       mix_inv [10];

  initial begin
    mix_sel = '{4'd2, 4'd7, 4'd1, 4'd8, 4'd3, 4'd4, 4'd6, 4'd5, 4'd0, 4'd9};
    mix_vec = '{8'h04, 8'h80, 8'h02, 8'h00, 8'h08, 8'h10, 8'h40, 8'h20, 8'h01, 8'h00};
    mix_inv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held for two edges with a live request pending.
    rst_n      = 1'b0;
    bus.wr_en  = 1'b1;
    bus.sel    = 4'd3;
    cyc();
    check("reset_0", 8'h00, 1'b0);
    cyc();
    check("reset_1", 8'h00, 1'b0);
    rst_n = 1'b1;
    cyc();
    check("post_reset_sel3", 8'h08, 1'b0);

    // Full sweep of valid indices.
    for (int i = 0; i < 8; i++) begin
      bus.sel = 4'(i);
      cyc();
      check($sformatf("sweep_%0d", i), 8'h01 << i, 1'b0);
    end

    // Out-of-range indices, including the alias candidate 9.
    bus.sel = 4'd8;
    cyc();
    check("oor_8", 8'h00, 1'b1);
    bus.sel = 4'd9;
    cyc();
    check("oor_9", 8'h00, 1'b1);
    bus.sel = 4'd15;
    cyc();
    check("oor_15", 8'h00, 1'b1);

    // Mixed back-to-back requests.
    for (int i = 0; i < 10; i++) begin
      bus.sel = mix_sel[i];
      cyc();
      check($sformatf("mix_%0d_sel%0d", i, mix_sel[i]), mix_vec[i], mix_inv[i]);
    end

    // wr_en gating, including an unknown index while idle.
    bus.wr_en = 1'b0;
    bus.sel   = 4'd5;
    cyc();
    check("gate_sel5", 8'h00, 1'b0);
    bus.sel = 4'bxxxx;
    cyc();
    check("gate_selx", 8'h00, 1'b0);
    bus.sel = 4'd12;
    cyc();
    check("gate_sel12", 8'h00, 1'b0);
    bus.wr_en = 1'b1;
    bus.sel   = 4'd5;
    cyc();
    check("ungate_sel5", 8'h20, 1'b0);

    // Reset mid-stream clears an active strobe despite wr_en.
    bus.sel = 4'd6;
    cyc();
    check("pre_rst_sel6", 8'h40, 1'b0);
    rst_n = 1'b0;
    cyc();
    check("mid_reset", 8'h00, 1'b0);
    rst_n = 1'b1;
    bus.sel = 4'd10;
    cyc();
    check("post_mid_reset_sel10", 8'h00, 1'b1);
    bus.sel = 4'd1;
    cyc();
    check("post_mid_reset_sel1", 8'h02, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sregister_decoder
